can_fifo_requester: RTL and testbench

//  CAN-side initiator of the write_fifo/read_fifo handshake into the AHB-to-CAN control unit.

---
 rtl/can_fifo_requester_pkg.sv | 22 ++
 rtl/can_fifo_requester_if.sv | 12 +
 rtl/can_fifo_requester_rx_queue.sv | 51 +++++
 rtl/can_fifo_requester.sv | 124 ++++++++++++
 tb/tb_can_fifo_requester.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/can_fifo_requester_pkg.sv
// Shared types and constants for the CAN-side write_fifo/read_fifo requester.
package can_req_pkg;

  localparam logic [31:0] CMD_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_HOLD,
    WR_GAP,
    RD_ISSUE,
    RD_WAIT,
    RD_SAMPLE,
    RD_DROP
  } req_state_t;

  typedef enum logic {
    DIR_WR,
    DIR_RD
  } dir_t;

endpackage

// File: rtl/can_fifo_requester_if.sv
// Requester <-> AHB-to-CAN control unit handshake: sensor-FIFO push and command-FIFO fetch.
interface can_fifo_requester_if;

  logic        write_fifo;
  logic [31:0] rx_data;
  logic        read_fifo;
  logic [31:0] tx_data;

  modport master (output write_fifo, rx_data, read_fifo, input tx_data);
  modport slave  (input write_fifo, rx_data, read_fifo, output tx_data);

endinterface

// File: rtl/can_fifo_requester_rx_queue.sv
// Synchronous receive-frame FIFO; pointers wrap naturally since DEPTH is a power of two.
module can_rx_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic        full,
  output logic        empty,
  output logic [31:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/can_fifo_requester.sv
// CAN-side initiator: pushes queued frames to the sensor FIFO and fetches commands, one request at a time.
// Optional CAN_REQ_STATS_EN builds saturating drop/empty-fetch counters; otherwise those ports read 0.
module can_fifo_requester #(
  parameter int unsigned RXQ_DEPTH = 4,
  parameter logic [31:0] CMD_EMPTY = 32'hFFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    rx_frame_valid,
  input  logic [31:0]             rx_frame,
  output logic                    rx_frame_ready,
  input  logic                    tx_req,
  output logic                    cmd_valid,
  output logic [31:0]             cmd_word,
  input  logic                    cmd_ack,
  output logic                    cmd_none,
  can_fifo_requester_if.master    cu,
  output logic                    busy,
  output logic [15:0]             drop_count,
  output logic [15:0]             empty_count
);

  import can_req_pkg::*;

  req_state_t  state, next_state;
  dir_t        last_dir;
  logic        q_full, q_empty;
  logic [31:0] q_head;
  logic [31:0] rx_data_q;
  logic        write, read;
  logic        wr_elig, rd_elig;

  can_rx_queue #(.DEPTH(RXQ_DEPTH)) u_rxq (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (rx_frame_valid),
    .pop   (state == WR_HOLD),
    .din   (rx_frame),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign rx_frame_ready = ~q_full;
  assign wr_elig        = ~q_empty;
  assign rd_elig        = tx_req & ~cmd_valid;

  always_comb begin
    next_state = state;
    write      = 1'b0;
    read       = 1'b0;
    cmd_none   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || last_dir == DIR_RD)) next_state = WR_ISSUE;
        else if (rd_elig)                                next_state = RD_ISSUE;
      end
      WR_ISSUE:  begin write = 1'b1; next_state = WR_HOLD; end
      WR_HOLD:   next_state = WR_GAP;
      WR_GAP:    next_state = IDLE;
      RD_ISSUE:  begin read = 1'b1; next_state = RD_WAIT; end
      RD_WAIT:   begin read = 1'b1; next_state = RD_SAMPLE; end
      RD_SAMPLE: begin
        read       = 1'b1;
        cmd_none   = (cu.tx_data == CMD_EMPTY);
        next_state = RD_DROP;
      end
      RD_DROP:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // busy also covers the IDLE cycle that launches a transaction
  assign busy = (state != IDLE) | (next_state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      last_dir  <= DIR_RD;
      rx_data_q <= '0;
      cmd_valid <= 1'b0;
      cmd_word  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == WR_ISSUE) begin
        last_dir  <= DIR_WR;
        rx_data_q <= q_head;
      end else if (state == IDLE && next_state == RD_ISSUE) begin
        last_dir <= DIR_RD;
      end
      if (state == RD_SAMPLE && !cmd_none) begin
        cmd_word  <= cu.tx_data;
        cmd_valid <= 1'b1;
      end else if (cmd_ack && cmd_valid) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign cu.write_fifo = write;
  assign cu.read_fifo  = read;
  assign cu.rx_data    = rx_data_q;

`ifdef CAN_REQ_STATS_EN
  logic [15:0] drop_q, empty_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_q  <= '0;
      empty_q <= '0;
    end else begin
      if (rx_frame_valid && q_full && drop_q != '1) drop_q  <= drop_q + 1'b1;
      if (cmd_none && empty_q != '1)                empty_q <= empty_q + 1'b1;
    end
  end

  assign drop_count  = drop_q;
  assign empty_count = empty_q;
`else
  assign drop_count  = '0;
  assign empty_count = '0;
`endif

endmodule

// File: tb/tb_can_fifo_requester.sv
// Directed bench for can_fifo_requester: cycle vector table plus overflow, arbitration and reset sequences.
module tb_can_fifo_requester;

`ifdef CAN_REQ_STATS_EN
  localparam logic [15:0] STAT1 = 16'd1;
`else
  localparam logic [15:0] STAT1 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rx_frame_valid;
  logic [31:0] rx_frame;
  logic        rx_frame_ready;
  logic        tx_req;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_ack;
  logic        cmd_none;
  logic        busy;
  logic [15:0] drop_count;
  logic [15:0] empty_count;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  can_fifo_requester_if bus();

  can_fifo_requester #(.RXQ_DEPTH(4), .CMD_EMPTY(32'hFFFF_FFFF)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .rx_frame_valid (rx_frame_valid),
    .rx_frame       (rx_frame),
    .rx_frame_ready (rx_frame_ready),
    .tx_req         (tx_req),
    .cmd_valid      (cmd_valid),
    .cmd_word       (cmd_word),
    .cmd_ack        (cmd_ack),
    .cmd_none       (cmd_none),
    .cu             (bus),
    .busy           (busy),
    .drop_count     (drop_count),
    .empty_count    (empty_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.write_fifo && bus.read_fifo) overlap++;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [31:0] f;
    logic        req;
    logic        ack;
    logic [31:0] td;
    logic [5:0]  flags;  // {write_fifo, read_fifo, busy, cmd_valid, cmd_none, rx_frame_ready}
    logic [31:0] rx;
    logic [31:0] cmd;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] f, logic req, logic ack, logic [31:0] td,
                              logic [5:0] flags, logic [31:0] rx, logic [31:0] cmd);
    vec_t r;
    r.v = v; r.f = f; r.req = req; r.ack = ack; r.td = td;
    r.flags = flags; r.rx = rx; r.cmd = cmd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    rx_frame_valid = 1'b0; rx_frame = '0; tx_req = 1'b0; cmd_ack = 1'b0; bus.tx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
  endtask

  localparam logic [31:0] F  = 32'h1234_5678;
  localparam logic [31:0] C1 = 32'hCAFE_0001;
  localparam logic [31:0] E  = 32'hFFFF_FFFF;

  vec_t vt[20];
  logic [31:0] got_wr[$];
  byte         events[$];
  byte         exp_ev[4];
  logic        prev_rf;
  logic        saw_wr;

  initial begin
    vt[0]  = mk(1, F, 0, 0, 0,  6'b000001, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0,  6'b001001, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0,  6'b101001, F, 0);
    vt[3]  = mk(0, 0, 0, 0, 0,  6'b001001, F, 0);
    vt[4]  = mk(0, 0, 0, 0, 0,  6'b001001, F, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,  6'b000001, F, 0);
    vt[6]  = mk(0, 0, 1, 0, C1, 6'b001001, F, 0);
    vt[7]  = mk(0, 0, 1, 0, C1, 6'b011001, F, 0);
    vt[8]  = mk(0, 0, 1, 0, C1, 6'b011001, F, 0);
    vt[9]  = mk(0, 0, 1, 0, C1, 6'b011001, F, 0);
    vt[10] = mk(0, 0, 0, 0, C1, 6'b001101, F, C1);
    vt[11] = mk(0, 0, 0, 0, C1, 6'b000101, F, C1);
    vt[12] = mk(0, 0, 0, 1, C1, 6'b000101, F, C1);
    vt[13] = mk(0, 0, 0, 0, C1, 6'b000001, F, C1);
    vt[14] = mk(0, 0, 1, 0, E,  6'b001001, F, C1);
    vt[15] = mk(0, 0, 1, 0, E,  6'b011001, F, C1);
    vt[16] = mk(0, 0, 1, 0, E,  6'b011001, F, C1);
    vt[17] = mk(0, 0, 1, 0, E,  6'b011011, F, C1);
    vt[18] = mk(0, 0, 0, 0, E,  6'b001001, F, C1);
    vt[19] = mk(0, 0, 0, 0, E,  6'b000001, F, C1);

    // reset state
    n_rst = 1'b0;
    rx_frame_valid = 1'b0; rx_frame = '0; tx_req = 1'b0; cmd_ack = 1'b0; bus.tx_data = '0;
    #12;
    chk("reset_flags", {bus.write_fifo, bus.read_fifo, busy, cmd_valid, cmd_none, rx_frame_ready}, 6'b000001);
    chk("reset_rx_data", bus.rx_data, 32'h0);
    chk("reset_cmd_word", cmd_word, 32'h0);
    chk("reset_counters", {drop_count, empty_count}, 32'h0);
    @(negedge clk) n_rst = 1'b1;

    // single write, single read, empty fetch
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx_frame_valid = vt[i].v; rx_frame = vt[i].f; tx_req = vt[i].req;
      cmd_ack = vt[i].ack; bus.tx_data = vt[i].td;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {bus.write_fifo, bus.read_fifo, busy, cmd_valid, cmd_none, rx_frame_ready, bus.rx_data, cmd_word},
          {vt[i].flags, vt[i].rx, vt[i].cmd});
    end
    chk("empty_count", empty_count, STAT1);

    // overflow: queue fills while a read occupies the FSM
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tx_req = (i == 0); bus.tx_data = E;
      rx_frame_valid = 1'b1; rx_frame = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("ovf_ready%0d", i), rx_frame_ready, (i < 4));
    end
    @(posedge clk); #1 rx_frame_valid = 1'b0;
    @(negedge clk);
    chk("drop_count", drop_count, STAT1);
    got_wr.delete();
    for (int k = 0; k < 40 && got_wr.size() < 4; k++) begin
      if (bus.write_fifo) got_wr.push_back(bus.rx_data);
      @(negedge clk);
    end
    chk("ovf_write_count", got_wr.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_order%0d", i), (i < got_wr.size()) ? got_wr[i] : 32'hX, 32'hA000_0000 + 32'(i));
    repeat (6) @(negedge clk);
    chk("ovf_no_extra_write", bus.write_fifo, 1'b0);

    // arbitration: both eligible from reset -> W R W R
    apply_reset();
    @(posedge clk); #1 rx_frame_valid = 1'b1; rx_frame = 32'hB0;
    @(posedge clk); #1 rx_frame = 32'hB1; tx_req = 1'b1; cmd_ack = 1'b1; bus.tx_data = 32'hCAFE_0002;
    @(posedge clk); #1 rx_frame_valid = 1'b0;
    events.delete();
    prev_rf = 1'b0;
    for (int k = 0; k < 60 && events.size() < 4; k++) begin
      @(negedge clk);
      if (bus.write_fifo) events.push_back("W");
      if (bus.read_fifo && !prev_rf) events.push_back("R");
      prev_rf = bus.read_fifo;
    end
    tx_req = 1'b0;
    exp_ev[0] = "W"; exp_ev[1] = "R"; exp_ev[2] = "W"; exp_ev[3] = "R";
    chk("arb_event_count", events.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_event%0d", i), (i < events.size()) ? events[i] : 8'h0, exp_ev[i]);
    repeat (8) @(negedge clk);
    cmd_ack = 1'b0;

    // reset during RD_WAIT
    apply_reset();
    @(posedge clk); #1 tx_req = 1'b1; bus.tx_data = 32'hCAFE_0003;
    @(posedge clk); #1 rx_frame_valid = 1'b1; rx_frame = 32'hD0;
    @(posedge clk); #1 rx_frame_valid = 1'b0;
    chk("rst_in_wait_rf", bus.read_fifo, 1'b1);
    #2 n_rst = 1'b0; tx_req = 1'b0;
    #1;
    chk("rst_async_flags", {bus.write_fifo, bus.read_fifo, busy, cmd_valid, rx_frame_ready}, 5'b00001);
    @(posedge clk); @(negedge clk) n_rst = 1'b1;
    saw_wr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.write_fifo || busy) saw_wr = 1'b1;
    end
    chk("rst_queue_empty", saw_wr, 1'b0);
    @(posedge clk); #1 tx_req = 1'b1;
    @(negedge clk);
    chk("rst_first_idle", {bus.read_fifo, busy}, 2'b01);
    @(negedge clk);
    chk("rst_first_issue", bus.read_fifo, 1'b1);
    tx_req = 1'b0;
    for (int k = 0; k < 10 && !cmd_valid; k++) @(negedge clk);
    chk("rst_fetch_valid", cmd_valid, 1'b1);
    chk("rst_fetch_word", cmd_word, 32'hCAFE_0003);

    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
